// File: rtl/sar_search.sv
// sar_search: successive-approximation controller recovering a comparator's unknown operand MSB first.
module sar_search #(
  parameter int WIDTH = 4,
  localparam int PW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             aeqb,
  input  logic             agtb,
  input  logic             altb,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             matched,
  output logic             err,
  output logic [PW-1:0]    probes
);
  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] acc, acc_next, next_guess;
  logic [PW-1:0] k;
  logic legal, fin;
  always_comb begin
    legal = {aeqb, agtb, altb} == 3'b100 || {aeqb, agtb, altb} == 3'b010 || {aeqb, agtb, altb} == 3'b001;
    fin = !legal || aeqb || k == '0;
    acc_next = agtb ? guess : acc;
    next_guess = acc_next | (WIDTH'(1) << (k - PW'(1)));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      guess <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      matched <= 1'b0;
      err <= 1'b0;
      probes <= '0;
      acc <= '0;
      k <= PW'(WIDTH - 1);
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          result <= '0;
          matched <= 1'b0;
          err <= 1'b0;
          probes <= '0;
          acc <= '0;
          k <= PW'(WIDTH - 1);
          guess <= WIDTH'(1) << (WIDTH - 1);
          busy <= 1'b1;
          state <= PROBE;
        end
        PROBE: begin
          probes <= probes + PW'(1);
          acc <= acc_next;
          k <= fin ? k : k - PW'(1);
          guess <= fin ? '0 : next_guess;
          busy <= !fin;
          done <= fin;
          state <= fin ? DONE : PROBE;
          // illegal flags win over an aeqb that arrives alongside another flag
          if (fin) begin
            err <= !legal;
            matched <= legal && aeqb;
            result <= !legal ? '0 : aeqb ? guess : acc_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sar_search.md
Name: sar_search

Overview:
- Successive-approximation search controller: the initiator side of the magnitude-comparator interface.
- Drives the comparator's `b` operand with trial values and reads back `aeqb`/`agtb`/`altb`.
- Recovers the unknown `a` operand bit by bit, MSB first, and stops early on equality.
- Sits beside a combinational comparator instance; `guess` feeds `b`, the comparator's flags feed back in the same cycle.

Parameters:
- WIDTH, 4: operand width in bits; must be ≥ 1.
- PW, $clog2(WIDTH+1): width of the probe counter. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a search; sampled only in IDLE.
- aeqb  in  1  comparator flag: a == guess.
- agtb  in  1  comparator flag: a > guess.
- altb  in  1  comparator flag: a < guess.
- guess  out  WIDTH  trial value driven to the comparator `b` input (registered).
- busy  out  1  high while in PROBE.
- done  out  1  one-cycle pulse when a search ends.
- result  out  WIDTH  recovered value of a; held until the next accepted start.
- matched  out  1  1 if the search ended on an aeqb hit; held.
- err  out  1  1 if the search aborted on illegal flags; held.
- probes  out  PW  number of comparisons used by the last search; held.

Behaviour:
- Reset (async, any state): state=IDLE, guess=0, busy=0, done=0, result=0, matched=0, err=0, probes=0, acc=0, bit index k=WIDTH-1.
- States: IDLE, PROBE, DONE.
- IDLE:
  - guess=0.
  - Edge with start=1: clear result/matched/err/probes and acc. Set k=WIDTH-1, guess=1<<(WIDTH-1). Go to PROBE.
- PROBE:
  - Comparator is combinational; flags are sampled at each rising edge against the current guess.
  - Each PROBE edge increments probes.
  - Flags not exactly one-hot (none set, or more than one set): err=1, result=0, matched=0. Go to DONE.
  - aeqb: result=guess, matched=1. Go to DONE.
  - agtb: acc_next = guess (keep bit k).
  - altb: acc_next = acc (drop bit k).
  - After agtb/altb:
    - If k==0: result=acc_next, matched=0. Go to DONE.
    - Else: k=k-1, guess = acc_next | (1<<(k-1)).
- DONE:
  - done=1 for exactly this cycle; guess=0; busy=0.
  - Next edge returns to IDLE unconditionally.
  - start is ignored here.
- Latency:
  - start accepted to done pulse = probes+1 cycles.
  - Worst case WIDTH+1, best case 2 (first-probe equality).
- start while busy or in DONE: ignored, no effect.
- a==0 never produces aeqb, since every guess is nonzero. Search runs WIDTH probes, result=0, matched=0, err=0.
- a==2^WIDTH-1 ends with aeqb on probe WIDTH, matched=1.
- Reset mid-search: immediate return to IDLE with all outputs zeroed; no done pulse.
- No arithmetic overflow is possible: guess is always a subset of acc plus one bit below every bit already decided.

Test Plan:
- Reset while idle, then release: all outputs 0, guess=0, busy=0.
- Comparator with a=4'd5, WIDTH=4, start pulse:
  - guess sequence 8, 4, 6, 5; aeqb on 5.
  - done one cycle later; result=5, matched=1, probes=4, err=0, busy high exactly 4 cycles.
- a=4'd8: guess 8 hits aeqb on the first probe -> done 2 cycles after start, result=8, probes=1, matched=1.
- a=4'd0:
  - guesses 8, 4, 2, 1, all altb.
  - result=0, matched=0, probes=4.
  - Also a=4'd15: guesses 8, 12, 14, 15 -> result=15, matched=1.
- Force flags to 3'b000 on the second probe of a search for a=11: err=1, result=0, probes=2, done pulse; a new start clears err.
- Assert rst during the third probe of a=11: outputs zero immediately, no done. Then start with a=11: guesses 8, 12, 10, 11 -> result=11. Assert start repeatedly while busy: no restart, same result.
